vend_coin_sequencer: RTL and testbench



---
 rtl/vend_coin_sequencer.sv | 171 +++++++++++++++++
 tb/tb_vend_coin_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_coin_sequencer.sv
// Vending-machine credit controller: round-robin coin arbitration, dispense handshake and change payout.
// Define VEND_TIMEOUT_EN to add an idle-collect timeout that refunds credit through a REFUND state.
module vend_coin_sequencer #(
  parameter int NUM_SLOTS   = 2,
  parameter int PRICE       = 5,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SLOTS-1:0] coin_valid,
  input  logic [NUM_SLOTS-1:0] coin_two,
  output logic [NUM_SLOTS-1:0] coin_ack,
  output logic                 vend_req,
  input  logic                 vend_done,
  output logic                 chg_valid,
  output logic                 chg_two,
  input  logic                 chg_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic [2:0]           state,
  output logic                 busy
);

  localparam int PtrW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CREDIT_W-1:0] PriceC = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] OneC   = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] TwoC   = CREDIT_W'(2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    VEND    = 3'd2,
    CHANGE  = 3'd3
`ifdef VEND_TIMEOUT_EN
    , REFUND = 3'd4
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [NUM_SLOTS-1:0]  ack_q, ack_d;
  logic [PtrW-1:0]       rr_q, rr_d;
  logic                  vend_req_q, vend_req_d;
  logic                  chg_valid_q, chg_valid_d;
  logic                  chg_two_q, chg_two_d;
  logic                  busy_q, busy_d;

  logic [NUM_SLOTS-1:0]  eligible;
  logic                  grant_vld;
  logic [PtrW-1:0]       grant_idx;

`ifdef VEND_TIMEOUT_EN
  localparam int TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  function automatic logic [PtrW-1:0] slotAfter(input logic [PtrW-1:0] base, input int k);
    return PtrW'((int'(base) + k) % NUM_SLOTS);
  endfunction

  // A slot whose ack is still high is masked so a held coin_valid is never granted twice.
  always_comb begin
    eligible  = coin_valid & ~ack_q;
    grant_vld = 1'b0;
    grant_idx = rr_q;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      if (!grant_vld && eligible[slotAfter(rr_q, k)]) begin
        grant_vld = 1'b1;
        grant_idx = slotAfter(rr_q, k);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    ack_d    = '0;
    rr_d     = rr_q;
`ifdef VEND_TIMEOUT_EN
    tmo_d    = '0;
`endif
    case (state_q)
      IDLE, COLLECT: begin
        if (grant_vld) begin
          ack_d[grant_idx] = 1'b1;
          credit_d = credit_q + (coin_two[grant_idx] ? TwoC : OneC);
          rr_d     = grant_idx;
          state_d  = (credit_d >= PriceC) ? VEND : COLLECT;
        end
`ifdef VEND_TIMEOUT_EN
        else if (state_q == COLLECT) begin
          if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
            state_d = REFUND;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
`endif
      end
      VEND: begin
        // vend_done only counts once the motor has actually seen vend_req.
        if (vend_req_q && vend_done) begin
          credit_d = credit_q - PriceC;
          state_d  = (credit_d == '0) ? IDLE : CHANGE;
        end
      end
      CHANGE
`ifdef VEND_TIMEOUT_EN
      , REFUND
`endif
      : begin
        if (chg_valid_q && chg_ready) begin
          credit_d = credit_q - (chg_two_q ? TwoC : OneC);
          if (credit_d == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase

    vend_req_d  = (state_q == VEND) && !(vend_req_q && vend_done);
    chg_valid_d = (state_d == CHANGE)
`ifdef VEND_TIMEOUT_EN
                  || (state_d == REFUND)
`endif
                  ;
    chg_two_d   = chg_valid_d && (credit_d >= TwoC);
    busy_d      = (state_d == VEND) || chg_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      ack_q       <= '0;
      rr_q        <= '0;
      vend_req_q  <= 1'b0;
      chg_valid_q <= 1'b0;
      chg_two_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      ack_q       <= ack_d;
      rr_q        <= rr_d;
      vend_req_q  <= vend_req_d;
      chg_valid_q <= chg_valid_d;
      chg_two_q   <= chg_two_d;
      busy_q      <= busy_d;
`ifdef VEND_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign coin_ack  = ack_q;
  assign vend_req  = vend_req_q;
  assign chg_valid = chg_valid_q;
  assign chg_two   = chg_two_q;
  assign credit    = credit_q;
  assign state     = state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vend_coin_sequencer.sv
// Bench for vend_coin_sequencer: directed vector table, hand-written corner sequences and
// randomized coin/motor/hopper traffic compared against a behavioural credit model.
module tb_vend_coin_sequencer;

  localparam int NumSlots   = 2;
  localparam int Price      = 5;
  localparam int CreditW    = 4;
  localparam int TimeoutCyc = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        coinValid, coinTwo, coinAck;
  logic              vendReq, vendDone, chgValid, chgTwo, chgReady;
  logic [CreditW-1:0] credit;
  logic [2:0]        state;
  logic              busy;

  int testsRun    = 0;
  int testsFailed = 0;

  // Behavioural model: modes use the published state codes, credit as a plain integer.
  int   mMode, mCredit, mLast, mAck, mTmo;
  logic mVendReq;

  typedef struct {
    logic [1:0] cv;
    logic [1:0] ct;
    logic       done;
    logic       rdy;
    int         st;
    int         cr;
    logic [1:0] ack;
    logic       vreq;
    logic       cvld;
    logic       ctwo;
  } vec_t;

  vec_t vecs[19];

  vend_coin_sequencer #(
    .NUM_SLOTS(NumSlots), .PRICE(Price), .CREDIT_W(CreditW), .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk(clk), .reset(reset),
    .coin_valid(coinValid), .coin_two(coinTwo), .coin_ack(coinAck),
    .vend_req(vendReq), .vend_done(vendDone),
    .chg_valid(chgValid), .chg_two(chgTwo), .chg_ready(chgReady),
    .credit(credit), .state(state), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [1:0] cv, input logic [1:0] ct, input logic done,
                              input logic rdy, input int st, input int cr, input logic [1:0] ack,
                              input logic vreq, input logic cvld, input logic ctwo);
    vec_t v;
    v.cv = cv; v.ct = ct; v.done = done; v.rdy = rdy;
    v.st = st; v.cr = cr; v.ack = ack; v.vreq = vreq; v.cvld = cvld; v.ctwo = ctwo;
    return v;
  endfunction

  // Drive one cycle of inputs from a negedge and return at the following negedge.
  task automatic applyStimulus(input logic [1:0] cv, input logic [1:0] ct, input logic done,
                               input logic rdy);
    coinValid = cv; coinTwo = ct; vendDone = done; chgReady = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int expState, input int expCredit,
                             input logic [1:0] expAck, input logic expVreq, input logic expCvld,
                             input logic expCtwo);
    logic expBusy;
    expBusy = (expState >= 2) && (expState <= 4);
    testsRun++;
    if (state !== 3'(expState) || credit !== CreditW'(expCredit) || coinAck !== expAck ||
        vendReq !== expVreq || chgValid !== expCvld || chgTwo !== expCtwo || busy !== expBusy) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state=%0d credit=%0d ack=%b vreq=%b cvld=%b ctwo=%b busy=%b, want state=%0d credit=%0d ack=%b vreq=%b cvld=%b ctwo=%b busy=%b",
               name, state, credit, coinAck, vendReq, chgValid, chgTwo, busy,
               expState, expCredit, expAck, expVreq, expCvld, expCtwo, expBusy);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    coinValid = '0; coinTwo = '0; vendDone = 1'b0; chgReady = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic modelReset();
    mMode = 0; mCredit = 0; mLast = 0; mAck = -1; mTmo = 0; mVendReq = 1'b0;
  endtask

  // One clock edge of the credit machine, computed from the sampled inputs.
  task automatic modelStep(input logic [1:0] cv, input logic [1:0] ct, input logic done,
                           input logic rdy);
    int   grant;
    int   prevAck;
    logic prevVreq;
    prevAck  = mAck;
    prevVreq = mVendReq;
    mAck     = -1;
    mVendReq = 1'b0;
    grant    = -1;
    case (mMode)
      0, 1: begin
        for (int k = 1; k <= NumSlots; k++) begin
          if (grant < 0 && cv[(mLast + k) % NumSlots] == 1'b1 && ((mLast + k) % NumSlots) != prevAck)
            grant = (mLast + k) % NumSlots;
        end
        if (grant >= 0) begin
          mCredit += (ct[grant] == 1'b1) ? 2 : 1;
          mLast = grant;
          mAck  = grant;
          mTmo  = 0;
          mMode = (mCredit >= Price) ? 2 : 1;
        end else if (mMode == 1) begin
          mTmo++;
`ifdef VEND_TIMEOUT_EN
          if (mTmo == TimeoutCyc) begin
            mMode = 4;
            mTmo  = 0;
          end
`endif
        end
      end
      2: begin
        if (prevVreq && done) begin
          mCredit -= Price;
          mMode = (mCredit == 0) ? 0 : 3;
        end else begin
          mVendReq = 1'b1;
        end
      end
      3, 4: begin
        if (rdy) begin
          mCredit -= (mCredit >= 2) ? 2 : 1;
          if (mCredit == 0) mMode = 0;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    reset = 1'b1;
    coinValid = '0; coinTwo = '0; vendDone = 1'b0; chgReady = 1'b0;
    @(negedge clk);
    checkOutput("resetHeld", 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("idleAfterReset", 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);

    // Exact payment 2+2+1, then overpayment 2+2+2 with a stalled change hopper.
    vecs[0]  = mk(2'b01, 2'b01, 1'b0, 1'b0, 1, 2, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(2'b01, 2'b01, 1'b0, 1'b0, 1, 4, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1, 4, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(2'b01, 2'b00, 1'b0, 1'b0, 2, 5, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 2, 5, 2'b00, 1'b1, 1'b0, 1'b0);
    vecs[6]  = mk(2'b00, 2'b00, 1'b1, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[8]  = mk(2'b01, 2'b01, 1'b0, 1'b0, 1, 2, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(2'b00, 2'b00, 1'b0, 1'b0, 1, 2, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(2'b01, 2'b01, 1'b0, 1'b0, 1, 4, 2'b01, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(2'b00, 2'b00, 1'b0, 1'b0, 1, 4, 2'b00, 1'b0, 1'b0, 1'b0);
    vecs[12] = mk(2'b10, 2'b10, 1'b0, 1'b0, 2, 6, 2'b10, 1'b0, 1'b0, 1'b0);
    vecs[13] = mk(2'b00, 2'b00, 1'b0, 1'b0, 2, 6, 2'b00, 1'b1, 1'b0, 1'b0);
    vecs[14] = mk(2'b00, 2'b00, 1'b1, 1'b0, 3, 1, 2'b00, 1'b0, 1'b1, 1'b0);
    vecs[15] = mk(2'b00, 2'b00, 1'b0, 1'b0, 3, 1, 2'b00, 1'b0, 1'b1, 1'b0);
    vecs[16] = mk(2'b00, 2'b00, 1'b0, 1'b0, 3, 1, 2'b00, 1'b0, 1'b1, 1'b0);
    vecs[17] = mk(2'b00, 2'b00, 1'b0, 1'b0, 3, 1, 2'b00, 1'b0, 1'b1, 1'b0);
    vecs[18] = mk(2'b00, 2'b00, 1'b0, 1'b1, 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].cv, vecs[i].ct, vecs[i].done, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].cr, vecs[i].ack,
                  vecs[i].vreq, vecs[i].cvld, vecs[i].ctwo);
    end

    // Both slots hold Rs1 coins; last grant was slot1, so service alternates starting at slot0.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(2'b11, 2'b00, 1'b0, 1'b0);
      checkOutput($sformatf("rrAlt%0d", k), (k == 4) ? 2 : 1, k + 1,
                  (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0, 1'b0);
    end

    // Slot1 coin held off while vending, then accepted right after returning to IDLE.
    applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
    checkOutput("heldInVend0", 2, 5, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
    checkOutput("heldInVend1", 2, 5, 2'b00, 1'b1, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b1, 1'b0);
    checkOutput("vendDoneExact", 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b10, 1'b0, 1'b0);
    checkOutput("heldCoinAcked", 1, 2, 2'b10, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("heldCoinDone", 1, 2, 2'b00, 1'b0, 1'b0, 1'b0);

    // Drive into CHANGE, then assert reset asynchronously between clock edges.
    applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
    checkOutput("preChangeVend", 2, 6, 2'b01, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b1, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("inChange", 3, 1, 2'b00, 1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 checkOutput("asyncResetMidChange", 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b1);
    checkOutput("idleAfterMidReset", 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);

`ifdef VEND_TIMEOUT_EN
    // Credit 3 left idle in COLLECT is refunded Rs2 first, then Rs1.
    applyStimulus(2'b01, 2'b01, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    applyStimulus(2'b01, 2'b00, 1'b0, 1'b0);
    checkOutput("tmoCredit3", 1, 3, 2'b01, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < TimeoutCyc - 1; k++) applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("tmoNotYet", 1, 3, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
    checkOutput("tmoRefund", 4, 3, 2'b00, 1'b0, 1'b1, 1'b1);
    applyStimulus(2'b01, 2'b01, 1'b0, 1'b1);
    checkOutput("refundTwo", 4, 1, 2'b00, 1'b0, 1'b1, 1'b0);
    applyStimulus(2'b01, 2'b01, 1'b0, 1'b1);
    checkOutput("refundOne", 0, 0, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0, 1'b0);
`endif

    // Randomized traffic against the behavioural model.
    pulseReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < NumSlots; s++) begin
        if (coinValid[s] && coinAck[s]) begin
          coinValid[s] = 1'b0;
        end else if (!coinValid[s] && $urandom_range(0, 3) == 0) begin
          coinValid[s] = 1'b1;
          coinTwo[s]   = 1'($urandom_range(0, 1));
        end
      end
      vendDone = vendReq && ($urandom_range(0, 2) == 0);
      chgReady = 1'($urandom_range(0, 1));
      @(posedge clk);
      modelStep(coinValid, coinTwo, vendDone, chgReady);
      @(negedge clk);
      checkOutput("random", mMode, mCredit, (mAck >= 0) ? 2'(1 << mAck) : 2'b00,
                  mVendReq, (mMode >= 3), (mMode >= 3) && (mCredit >= 2));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
